// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready load/store requests against a synchronous-read word array,
// with little-endian lane steering, sign/zero extension and two-word splitting of misaligned accesses.
module data_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_length,
    input  logic        req_signed,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = 33'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t        state_q, state_d;
    logic          write_q, write_d;
    logic          signed_q, signed_d;
    logic [1:0]    len_q, len_d;
    logic [1:0]    boff_q, boff_d;
    logic [AW-1:0] w0_q, w0_d;
    logic          split_q, split_d;
    logic          err_q, err_d;
    logic          load_q, load_d;
    logic [31:0]   wdata_q, wdata_d;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   rd0_q, rd1_q;

    logic [31:0]   off;
    logic [2:0]    nbytes;
    logic [32:0]   end_off;
    logic          dec_err, dec_split, accept;

    always_comb begin
        off       = req_address - BASE_ADDR;
        case (req_length)
            2'b01:   nbytes = 3'd1;
            2'b10:   nbytes = 3'd2;
            2'b11:   nbytes = 3'd4;
            default: nbytes = 3'd0;
        endcase
        // 33-bit sum so addresses below BASE_ADDR (huge offsets) cannot wrap back into range
        end_off   = {1'b0, off} + 33'(nbytes);
        dec_err   = (req_length != 2'b00) && (end_off > LIMIT);
        dec_split = ({1'b0, off[1:0]} + nbytes) > 3'd4;
        req_ready = (state_q == IDLE) && SYS_reset_n;
        accept    = req_valid && req_ready;
    end

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        signed_d = signed_q;
        len_d    = len_q;
        boff_d   = boff_q;
        w0_d     = w0_q;
        split_d  = split_q;
        err_d    = err_q;
        load_d   = load_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d  = req_write;
                    signed_d = req_signed;
                    len_d    = req_length;
                    boff_d   = off[1:0];
                    w0_d     = off[AW+1:2];
                    split_d  = dec_split;
                    err_d    = dec_err;
                    load_d   = !req_write && (req_length != 2'b00) && !dec_err;
                    wdata_d  = req_wdata;
                    state_d  = (dec_err || req_length == 2'b00) ? RESP : ACC0;
                end
            end
            ACC0:    state_d = split_q ? ACC1 : RESP;
            ACC1:    state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            len_q    <= 2'b00;
            boff_q   <= 2'b00;
            w0_q     <= '0;
            split_q  <= 1'b0;
            err_q    <= 1'b0;
            load_q   <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            signed_q <= signed_d;
            len_q    <= len_d;
            boff_q   <= boff_d;
            w0_q     <= w0_d;
            split_q  <= split_d;
            err_q    <= err_d;
            load_q   <= load_d;
            wdata_q  <= wdata_d;
        end
    end

    // Byte enables and data steered across the {w1,w0} lane pair
    logic [7:0]    mask8, be8;
    logic [63:0]   data64;
    logic          mem_we;
    logic [AW-1:0] mem_idx;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wd;

    always_comb begin
        case (len_q)
            2'b01:   mask8 = 8'h01;
            2'b10:   mask8 = 8'h03;
            2'b11:   mask8 = 8'h0F;
            default: mask8 = 8'h00;
        endcase
        be8     = mask8 << boff_q;
        data64  = {32'h0, wdata_q} << {boff_q, 3'b000};
        mem_idx = (state_q == ACC1) ? (w0_q + 1'b1) : w0_q;
        mem_we  = write_q && (state_q == ACC0 || state_q == ACC1);
        mem_be  = (state_q == ACC1) ? be8[7:4] : be8[3:0];
        mem_wd  = (state_q == ACC1) ? data64[63:32] : data64[31:0];
    end

    always_ff @(posedge SYS_clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
            end
        end
        if (state_q == ACC0) rd0_q <= mem[mem_idx];
        if (state_q == ACC1) rd1_q <= mem[mem_idx];
    end

    logic [63:0] pair;
    logic [31:0] sh, ext;

    always_comb begin
        pair = {split_q ? rd1_q : 32'h0, rd0_q};
        sh   = 32'(pair >> {boff_q, 3'b000});
        case (len_q)
            2'b01:   ext = signed_q ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
            2'b10:   ext = signed_q ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
            default: ext = sh;
        endcase
        resp_valid = (state_q == RESP);
        resp_error = (state_q == RESP) && err_q;
        resp_rdata = ((state_q == RESP) && load_q) ? ext : 32'h0;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: hand-computed loads/stores, latency, range errors,
// mid-operation reset and back-to-back handshake.
module tb_data_mem_responder;
    logic        SYS_clk = 1'b0;
    logic        SYS_reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_length = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_address = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] B = 32'h1000_0000;

    data_mem_responder dut (
        .SYS_clk     (SYS_clk),
        .SYS_reset_n (SYS_reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_length  (req_length),
        .req_signed  (req_signed),
        .req_address (req_address),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_error  (resp_error)
    );

    always #5 SYS_clk = ~SYS_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [1:0] len, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_write   = wr;
        req_length  = len;
        req_signed  = sg;
        req_address = addr;
        req_wdata   = wd;
    endtask

    task automatic do_req(input logic wr, input logic [1:0] len, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er);
        int n;
        @(negedge SYS_clk);
        drive(wr, len, sg, addr, wd);
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge SYS_clk);
            n++;
        end
        @(posedge SYS_clk);
        #1 req_valid = 1'b0;
        lat = 0;
        rd  = 32'h0;
        er  = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge SYS_clk);
            if (resp_valid) begin
                lat = k;
                rd  = resp_rdata;
                er  = resp_error;
                break;
            end
        end
    endtask

    task automatic req_chk(input string tag, input logic wr, input logic [1:0] len, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int exp_lat, input logic [31:0] exp_rd, input logic exp_er);
        int lat;
        logic [31:0] rd;
        logic er;
        do_req(wr, len, sg, addr, wd, lat, rd, er);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rdata"}, rd, exp_rd);
        check({tag, " error"}, {31'h0, er}, {31'h0, exp_er});
        @(negedge SYS_clk);
        check({tag, " valid after"}, {31'h0, resp_valid}, 32'h0);
        check({tag, " rdata after"}, resp_rdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] exp_v;
        logic [5:0] exp_r;
        exp_v = 6'b010010;
        exp_r = 6'b100100;

        // reset state
        repeat (2) @(negedge SYS_clk);
        check("rst ready", {31'h0, req_ready}, 32'h0);
        check("rst valid", {31'h0, resp_valid}, 32'h0);
        check("rst rdata", resp_rdata, 32'h0);
        check("rst error", {31'h0, resp_error}, 32'h0);
        SYS_reset_n = 1'b1;
        #1 check("ready after rst", {31'h0, req_ready}, 32'h1);

        // aligned word and sub-word loads
        req_chk("sw 10",  1'b1, 2'b11, 1'b0, B + 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0);
        req_chk("lw 10",  1'b0, 2'b11, 1'b0, B + 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0);
        req_chk("lb 13",  1'b0, 2'b01, 1'b1, B + 32'h13, 32'h0, 2, 32'hFFFFFFDE, 1'b0);
        req_chk("lbu 13", 1'b0, 2'b01, 1'b0, B + 32'h13, 32'h0, 2, 32'h000000DE, 1'b0);
        req_chk("lh 12",  1'b0, 2'b10, 1'b1, B + 32'h12, 32'h0, 2, 32'hFFFFDEAD, 1'b0);
        req_chk("lhu 10", 1'b0, 2'b10, 1'b0, B + 32'h10, 32'h0, 2, 32'h0000BEEF, 1'b0);

        // split store and loads
        req_chk("sw 14", 1'b1, 2'b11, 1'b0, B + 32'h14, 32'hAABBCCDD, 2, 32'h0, 1'b0);
        req_chk("sw 18", 1'b1, 2'b11, 1'b0, B + 32'h18, 32'h55667788, 2, 32'h0, 1'b0);
        req_chk("sw 16 split", 1'b1, 2'b11, 1'b0, B + 32'h16, 32'h11223344, 3, 32'h0, 1'b0);
        req_chk("lw 14", 1'b0, 2'b11, 1'b0, B + 32'h14, 32'h0, 2, 32'h3344CCDD, 1'b0);
        req_chk("lw 18", 1'b0, 2'b11, 1'b0, B + 32'h18, 32'h0, 2, 32'h55661122, 1'b0);
        req_chk("lw 16 split", 1'b0, 2'b11, 1'b0, B + 32'h16, 32'h0, 3, 32'h11223344, 1'b0);
        req_chk("lh 13 split", 1'b0, 2'b10, 1'b1, B + 32'h13, 32'h0, 3, 32'hFFFFDDDE, 1'b0);
        req_chk("lhu 17 split", 1'b0, 2'b10, 1'b0, B + 32'h17, 32'h0, 3, 32'h00002233, 1'b0);

        // range errors and top-of-array boundary
        req_chk("sw FFC", 1'b1, 2'b11, 1'b0, B + 32'hFFC, 32'hCAFEF00D, 2, 32'h0, 1'b0);
        req_chk("lw 1000 err", 1'b0, 2'b11, 1'b0, B + 32'h1000, 32'h0, 1, 32'h0, 1'b1);
        req_chk("sw FFE err", 1'b1, 2'b11, 1'b0, B + 32'hFFE, 32'h12345678, 1, 32'h0, 1'b1);
        req_chk("lw FFC kept", 1'b0, 2'b11, 1'b0, B + 32'hFFC, 32'h0, 2, 32'hCAFEF00D, 1'b0);
        req_chk("lb FFF edge", 1'b0, 2'b01, 1'b1, B + 32'hFFF, 32'h0, 2, 32'hFFFFFFCA, 1'b0);
        req_chk("lw under err", 1'b0, 2'b11, 1'b0, 32'h0FFF_FFFC, 32'h0, 1, 32'h0, 1'b1);

        // reset in the middle of a split store
        req_chk("sw 20", 1'b1, 2'b11, 1'b0, B + 32'h20, 32'h01020304, 2, 32'h0, 1'b0);
        req_chk("sw 24", 1'b1, 2'b11, 1'b0, B + 32'h24, 32'h05060708, 2, 32'h0, 1'b0);
        @(negedge SYS_clk);
        drive(1'b1, 2'b11, 1'b0, B + 32'h22, 32'hA1B2C3D4);
        req_valid = 1'b1;
        @(posedge SYS_clk);
        #1 req_valid = 1'b0;
        @(negedge SYS_clk);
        check("mid acc0 valid", {31'h0, resp_valid}, 32'h0);
        @(posedge SYS_clk);
        @(negedge SYS_clk);
        SYS_reset_n = 1'b0;
        #1;
        check("mid rst ready", {31'h0, req_ready}, 32'h0);
        check("mid rst valid", {31'h0, resp_valid}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge SYS_clk);
            check($sformatf("mid rst valid %0d", k), {31'h0, resp_valid}, 32'h0);
            check($sformatf("mid rst ready %0d", k), {31'h0, req_ready}, 32'h0);
        end
        SYS_reset_n = 1'b1;
        #1 check("mid release ready", {31'h0, req_ready}, 32'h1);
        req_chk("lw 20 after rst", 1'b0, 2'b11, 1'b0, B + 32'h20, 32'h0, 2, 32'hC3D40304, 1'b0);
        req_chk("lw 24 after rst", 1'b0, 2'b11, 1'b0, B + 32'h24, 32'h0, 2, 32'h05060708, 1'b0);

        // back-to-back with req_valid held high
        @(negedge SYS_clk);
        drive(1'b0, 2'b11, 1'b0, B + 32'h10, 32'h0);
        req_valid = 1'b1;
        @(posedge SYS_clk);
        #1 drive(1'b0, 2'b11, 1'b0, B + 32'h14, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge SYS_clk);
            if (k == 4) req_valid = 1'b0;
            check($sformatf("b2b valid %0d", k), {31'h0, resp_valid}, {31'h0, exp_v[k-1]});
            check($sformatf("b2b ready %0d", k), {31'h0, req_ready}, {31'h0, exp_r[k-1]});
            if (k == 2) check("b2b rdata A", resp_rdata, 32'hDEADBEEF);
            if (k == 5) check("b2b rdata B", resp_rdata, 32'h3344CCDD);
        end

        // length 00 no-op store leaves array unchanged
        req_chk("nop store", 1'b1, 2'b00, 1'b0, B + 32'h10, 32'hFFFFFFFF, 1, 32'h0, 1'b0);
        req_chk("nop load",  1'b0, 2'b00, 1'b1, B + 32'h10, 32'h0, 1, 32'h0, 1'b0);
        req_chk("lw 10 kept", 1'b0, 2'b11, 1'b0, B + 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
